// File: rtl/mips_pkg.sv
// Shared types for the 5-stage MIPS pipeline control.
// Sequencer states, branch-stage codes, stage bundles.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN,
    HALTED
  } ctrl_state_t;

  localparam int BR_EX  = 2;
  localparam int BR_MEM = 3;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } stage_flush_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the load in EX and the
// sources of the instruction in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              uses_rs,
  input  logic              uses_rt,
  input  logic              mem_read,
  input  logic [REG_AW-1:0] wr_addr,
  output logic              load_use
);

  logic rs_hit;
  logic rt_hit;
  logic wr_live;

  // $zero is never a real producer.
  assign wr_live  = (wr_addr != '0);
  assign rs_hit   = uses_rs && (rs_addr == wr_addr);
  assign rt_hit   = uses_rt && (rt_addr == wr_addr);
  assign load_use = mem_read && wr_live
                 && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Fetch PC owner and stage enable/flush sequencer.
// Handles load-use, redirects, imem waits and halt.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int REG_AW    = 5,
  parameter int RESET_PC  = 0,
  parameter int BR_STAGE  = 3,
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_wr_addr,
  input  logic              id_jump,
  input  logic [PC_W-1:0]   id_jump_addr,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              imem_ready,
  input  logic              halt_req,
  output logic [PC_W-1:0]   pc,
  output logic              pc_valid,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int DW =
    (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DLAST =
    DW'(DRAIN_CYC - 1);
  localparam logic BR_FL_MEM =
    (BR_STAGE == BR_MEM);
  localparam logic [PC_W-1:0] PC_RST =
    PC_W'(RESET_PC);

  if (BR_STAGE != BR_EX && BR_STAGE != BR_MEM)
  begin : g_bad_br_stage
    $error("BR_STAGE must be 2 (EX) or 3 (MEM)");
  end

  ctrl_state_t       state;
  ctrl_state_t       state_nx;
  logic [PC_W-1:0]   pc_nx;
  logic [DW-1:0]     dcnt;
  logic [DW-1:0]     dcnt_nx;
  logic              rst_q;
  logic              load_use;
  logic              stall_inc;
  logic              flush_inc;
  logic              pc_valid_c;
  logic              halt_take;
  logic              sel_br;
  logic              sel_jmp;
  logic              sel_lu;
  logic              sel_wait;
  logic              sel_adv;
  stage_en_t         en;
  stage_flush_t      fl;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .rs_addr  (id_rs_addr),
    .rt_addr  (id_rt_addr),
    .uses_rs  (id_uses_rs),
    .uses_rt  (id_uses_rt),
    .mem_read (idex_mem_read),
    .wr_addr  (idex_wr_addr),
    .load_use (load_use)
  );

  // One-hot RUN action, highest priority wins.
  assign sel_br   = br_taken;
  assign sel_jmp  = id_jump && !br_taken;
  assign sel_lu   = load_use && !br_taken
                 && !id_jump;
  assign sel_wait = !imem_ready && !load_use
                 && !br_taken && !id_jump;
  assign sel_adv  = imem_ready && !load_use
                 && !br_taken && !id_jump;

  assign halt_take = halt_req && !br_taken
                  && !id_jump;

  // Release synchroniser; BOOT waits for it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  // State, fetch PC and drain counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= PC_RST;
      dcnt  <= '0;
    end else if (rst_q) begin
      state <= state_nx;
      pc    <= pc_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // Next state, next PC and stage controls.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    dcnt_nx    = dcnt;
    en         = '0;
    fl         = '0;
    pc_valid_c = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (rst_q) begin
      unique case (state)
        BOOT: begin
          en       = '1;
          fl       = '1;
          state_nx = RUN;
        end
        RUN: begin
          pc_valid_c = 1'b1;
          en         = '1;
          unique case (1'b1)
            sel_br: begin
              pc_nx     = br_target;
              fl.if_id  = 1'b1;
              fl.id_ex  = 1'b1;
              fl.ex_mem = BR_FL_MEM;
              flush_inc = 1'b1;
            end
            sel_jmp: begin
              pc_nx     = id_jump_addr;
              fl.if_id  = 1'b1;
              flush_inc = 1'b1;
            end
            sel_lu: begin
              en.if_id  = 1'b0;
              fl.id_ex  = 1'b1;
              stall_inc = 1'b1;
            end
            sel_wait: begin
              fl.if_id  = 1'b1;
              stall_inc = 1'b1;
            end
            sel_adv: begin
              pc_nx = pc + PC_W'(1);
            end
            default: ;
          endcase
          // Drop the fetch at pc; it resumes there.
          if (halt_take) begin
            state_nx = DRAIN;
            dcnt_nx  = '0;
            pc_nx    = pc;
            if (!load_use) fl.if_id = 1'b1;
          end
        end
        DRAIN: begin
          en       = '1;
          fl.if_id = 1'b1;
          if (br_taken) begin
            pc_nx     = br_target;
            fl.id_ex  = 1'b1;
            fl.ex_mem = BR_FL_MEM;
            flush_inc = 1'b1;
          end
          if (dcnt == DLAST) state_nx = HALTED;
          else dcnt_nx = dcnt + DW'(1);
        end
        HALTED: begin
          if (!halt_req) state_nx = RUN;
        end
        default: state_nx = BOOT;
      endcase
    end
  end

  // Saturating stall/flush statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign pc_valid     = pc_valid_c;
  assign if_id_en     = en.if_id;
  assign id_ex_en     = en.id_ex;
  assign ex_mem_en    = en.ex_mem;
  assign mem_wb_en    = en.mem_wb;
  assign if_id_flush  = fl.if_id;
  assign id_ex_flush  = fl.id_ex;
  assign ex_mem_flush = fl.ex_mem;
  assign halted       = (state == HALTED);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a
// rule-level reference model checked every cycle.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs_addr, id_rt_addr;
  logic       id_uses_rs, id_uses_rt;
  logic       idex_mem_read;
  logic [4:0] idex_wr_addr;
  logic       id_jump;
  logic [4:0] id_jump_addr;
  logic       br_taken;
  logic [4:0] br_target;
  logic       imem_ready, halt_req;
  logic [4:0] pc;
  logic       pc_valid;
  logic       if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;
  logic       halted;
  logic [3:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(
    .PC_W(5), .REG_AW(5), .RESET_PC(0),
    .BR_STAGE(3), .DRAIN_CYC(4), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read),
    .idex_wr_addr(idex_wr_addr),
    .id_jump(id_jump), .id_jump_addr(id_jump_addr),
    .br_taken(br_taken), .br_target(br_target),
    .imem_ready(imem_ready), .halt_req(halt_req),
    .pc(pc), .pc_valid(pc_valid),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] pc;
    logic       v;
    logic [3:0] en;
    logic [2:0] fl;
    logic       h;
    logic [3:0] sc;
    logic [3:0] fc;
  } obs_t;

  // Model: mode 0 reset, 1 boot, 2 run, 3 drain, 4 halted
  int m_st = 0;
  int m_pc = 0;
  int m_dr = 0;
  int m_sc = 0;
  int m_fc = 0;

  function automatic bit model_lu();
    bit hit;
    hit = (id_uses_rs && id_rs_addr == idex_wr_addr)
       || (id_uses_rt && id_rt_addr == idex_wr_addr);
    return idex_mem_read && idex_wr_addr != 0 && hit;
  endfunction

  function automatic int sat15(input int x);
    return (x >= 15) ? 15 : x + 1;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o    = '0;
    o.pc = 5'(m_pc);
    o.sc = 4'(m_sc);
    o.fc = 4'(m_fc);
    case (m_st)
      1: begin o.en = 4'hf; o.fl = 3'b111; end
      2: begin
        o.v  = 1'b1;
        o.en = 4'hf;
        if (br_taken) o.fl = 3'b111;
        else if (id_jump) o.fl = 3'b100;
        else if (model_lu()) begin
          o.en = 4'b0111;
          o.fl = 3'b010;
        end else if (!imem_ready || halt_req)
          o.fl = 3'b100;
      end
      3: begin
        o.en = 4'hf;
        o.fl = br_taken ? 3'b111 : 3'b100;
      end
      4: o.h = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge reset) begin
    m_st = 0; m_pc = 0; m_dr = 0; m_sc = 0; m_fc = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      case (m_st)
        0: m_st = 1;
        1: m_st = 2;
        2: begin
          if (br_taken) begin
            m_pc = br_target; m_fc = sat15(m_fc);
          end else if (id_jump) begin
            m_pc = id_jump_addr; m_fc = sat15(m_fc);
          end else begin
            if (model_lu() || !imem_ready)
              m_sc = sat15(m_sc);
            else if (!halt_req)
              m_pc = (m_pc + 1) % 32;
            if (halt_req) begin m_st = 3; m_dr = 0; end
          end
        end
        3: begin
          if (br_taken) begin
            m_pc = br_target; m_fc = sat15(m_fc);
          end
          m_dr++;
          if (m_dr == 4) m_st = 4;
        end
        4: if (!halt_req) m_st = 2;
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    obs_t act, exp_o;
    act = {pc, pc_valid,
           {if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
           {if_id_flush, id_ex_flush, ex_mem_flush},
           halted, stall_cnt, flush_cnt};
    exp_o = model_out();
    total++;
    if (act !== exp_o) begin
      bad++;
      $display("FAIL model_cmp t=%0t got=%h want=%h",
               $time, act, exp_o);
    end
  end

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0;
    id_rs_addr = 0; id_rt_addr = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    idex_mem_read = 0; idex_wr_addr = 0;
    id_jump = 0; id_jump_addr = 0;
    br_taken = 0; br_target = 0;
    imem_ready = 1; halt_req = 0;
    repeat (2) tick();
    chk("rst_pc", 8'(pc), 8'd0);
    chk("rst_en", 8'({if_id_en, id_ex_en, ex_mem_en,
                      mem_wb_en}), 8'd0);
    chk("rst_fl", 8'({if_id_flush, id_ex_flush,
                      ex_mem_flush}), 8'd0);
    chk("rst_valid", 8'(pc_valid), 8'd0);

    reset = 1;
    #1 chk("release_en", 8'(if_id_en), 8'd0);
    tick();
    chk("boot_fl", 8'({if_id_flush, id_ex_flush,
                       ex_mem_flush}), 8'd7);
    chk("boot_valid", 8'(pc_valid), 8'd0);
    chk("boot_en", 8'(mem_wb_en), 8'd1);
    tick();
    chk("run_pc0", 8'(pc), 8'd0);
    chk("run_valid", 8'(pc_valid), 8'd1);
    repeat (31) tick();
    chk("pc31", 8'(pc), 8'd31);
    tick();
    chk("pc_wrap", 8'(pc), 8'd0);
    repeat (3) tick();

    idex_mem_read = 1; idex_wr_addr = 8;
    id_rt_addr = 8; id_uses_rt = 1;
    #1;
    chk("lu_ifid_en", 8'(if_id_en), 8'd0);
    chk("lu_idex_fl", 8'(id_ex_flush), 8'd1);
    tick();
    chk("lu_pc", 8'(pc), 8'd3);
    chk("lu_stall", 8'(stall_cnt), 8'd1);
    idex_wr_addr = 0; id_rt_addr = 0;
    #1 chk("r0_ifid_en", 8'(if_id_en), 8'd1);
    tick();
    chk("r0_pc", 8'(pc), 8'd4);
    chk("r0_stall", 8'(stall_cnt), 8'd1);
    idex_mem_read = 0; id_uses_rt = 0;

    br_taken = 1; br_target = 12;
    id_jump = 1; id_jump_addr = 20;
    #1 chk("br_fl", 8'({if_id_flush, id_ex_flush,
                        ex_mem_flush}), 8'd7);
    tick();
    chk("br_pc", 8'(pc), 8'd12);
    chk("br_fcnt", 8'(flush_cnt), 8'd1);
    br_taken = 0; id_jump = 0;

    imem_ready = 0;
    repeat (3) begin
      #1 chk("wait_fl", 8'(if_id_flush), 8'd1);
      tick();
      chk("wait_pc", 8'(pc), 8'd12);
    end
    chk("wait_stall", 8'(stall_cnt), 8'd4);
    imem_ready = 1;

    id_jump = 1; id_jump_addr = 7;
    #1 chk("jmp_fl", 8'({if_id_flush, id_ex_flush,
                         ex_mem_flush}), 8'd4);
    tick();
    chk("jmp_pc", 8'(pc), 8'd7);
    chk("jmp_fcnt", 8'(flush_cnt), 8'd2);
    id_jump = 0;

    halt_req = 1;
    #1 chk("hacc_fl", 8'(if_id_flush), 8'd1);
    tick();
    repeat (4) begin
      chk("drain_valid", 8'(pc_valid), 8'd0);
      chk("drain_halted", 8'(halted), 8'd0);
      tick();
    end
    chk("halted", 8'(halted), 8'd1);
    chk("halt_en", 8'({if_id_en, id_ex_en, ex_mem_en,
                       mem_wb_en}), 8'd0);
    chk("halt_pc", 8'(pc), 8'd7);
    tick();
    chk("halt_hold", 8'(halted), 8'd1);
    halt_req = 0;
    #1 chk("halt_exit_wait", 8'(halted), 8'd1);
    tick();
    chk("resume_halted", 8'(halted), 8'd0);
    chk("resume_pc", 8'(pc), 8'd7);
    chk("resume_valid", 8'(pc_valid), 8'd1);

    imem_ready = 0;
    repeat (20) tick();
    chk("stall_sat", 8'(stall_cnt), 8'd15);
    imem_ready = 1;

    halt_req = 1;
    tick();
    tick();
    reset = 0;
    #1;
    chk("mid_pc", 8'(pc), 8'd0);
    chk("mid_en", 8'({if_id_en, id_ex_en, ex_mem_en,
                      mem_wb_en}), 8'd0);
    chk("mid_fl", 8'({if_id_flush, id_ex_flush,
                      ex_mem_flush}), 8'd0);
    chk("mid_stall", 8'(stall_cnt), 8'd0);
    chk("mid_halted", 8'(halted), 8'd0);
    halt_req = 0;
    tick();
    reset = 1;
    tick();
    chk("boot2_fl", 8'(if_id_flush), 8'd1);
    tick();
    chk("run2_pc", 8'(pc), 8'd0);
    repeat (2) tick();
    chk("run2_pc2", 8'(pc), 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised pipeline sequencer for the 5-stage MIPS core. Owns the fetch PC and drives the per-stage register enables and flushes, replacing the fixed "fill then follow MEM/WB PC" logic and the constant-1 stage enables. Detects load-use hazards, redirects on jumps (resolved in ID) and taken branches (resolved at stage `BR_STAGE`), and absorbs instruction-memory wait states. Supports a halt/drain/resume mode and keeps stall/flush statistics.

## Interface
Parameters:
- `PC_W`, 5, fetch PC width in instruction-index units; instruction space is 2^PC_W.
- `REG_AW`, 5, register address width.
- `RESET_PC`, 0, PC loaded on reset.
- `BR_STAGE`, 3, stage that resolves branches; 2 = EX, 3 = MEM. Any other value is an elaboration error.
- `DRAIN_CYC`, 4, bubble cycles needed to empty ID..WB on halt.
- `CNT_W`, 16, statistics counter width.

Ports:
- `clk`, in, 1, clock.
- `reset`, in, 1, asynchronous, active-low reset.
- `id_rs_addr` / `id_rt_addr`, in, REG_AW each, source registers of the instruction in ID.
- `id_uses_rs` / `id_uses_rt`, in, 1 each, source is actually read.
- `idex_mem_read`, in, 1, instruction in EX is a load.
- `idex_wr_addr`, in, REG_AW, destination of the instruction in EX.
- `id_jump`, in, 1, jump decoded in ID.
- `id_jump_addr`, in, PC_W, jump target.
- `br_taken`, in, 1, branch taken at `BR_STAGE`.
- `br_target`, in, PC_W, branch target.
- `imem_ready`, in, 1, instruction memory returns valid data for `pc` this cycle.
- `halt_req`, in, 1, level request to halt.
- `pc`, out, PC_W, fetch address.
- `pc_valid`, out, 1, fetch active.
- `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`, out, 1 each, stage register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, out, 1 each, load a bubble (zero control) at the next edge.
- `halted`, out, 1, state == HALTED.
- `stall_cnt`, `flush_cnt`, out, CNT_W each, saturating statistics.

## Operation
- States: BOOT, RUN, DRAIN, HALTED.
  - BOOT lasts exactly one cycle after reset release: `pc_valid` = 0, enables = 1, all flushes = 1. It then goes to RUN.
- RUN. Conditions below are listed highest priority first; only the first true row acts:
  - `br_taken`:
    - `pc` <= `br_target`.
    - `if_id_flush` = `id_ex_flush` = 1; `ex_mem_flush` = 1 only if BR_STAGE = 3.
    - `flush_cnt` += 1.
  - `id_jump`: `pc` <= `id_jump_addr`; `if_id_flush` = 1; `flush_cnt` += 1.
  - Load-use. Condition: `idex_mem_read` and `idex_wr_addr` ≠ 0, and either (`id_uses_rs` and rs matches) or (`id_uses_rt` and rt matches).
    - Response: `pc` held, `if_id_en` = 0, `id_ex_flush` = 1, `stall_cnt` += 1.
  - `!imem_ready`: `pc` held, `if_id_flush` = 1, later stages advance; `stall_cnt` += 1.
  - Otherwise: `pc` <= `pc` + 1, modulo 2^PC_W (wraps all-ones -> 0).
- `halt_req` sampled in RUN only when no redirect is active that cycle:
  - State -> DRAIN; `pc` holds the next unfetched address.
  - If a redirect is active, the redirect is taken first and the halt is accepted on the next cycle.
- DRAIN:
  - `pc_valid` = 0, `if_id_flush` = 1.
  - Counts DRAIN_CYC cycles, then -> HALTED.
  - `br_taken` during DRAIN still updates `pc` and applies the flushes.
- HALTED:
  - All enables = 0, flushes = 0, `pc_valid` = 0.
  - On `halt_req` = 0, returns to RUN next cycle, fetching from the held `pc`.
- `halt_req` deasserted during DRAIN: the drain completes, then HALTED exits on the next cycle.
- Statistics counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset (asynchronous assert):
  - State BOOT, `pc` = RESET_PC, counters = 0.
  - All enables = 0, all flushes = 0, `pc_valid` = 0, `halted` = 0.
- Deassertion is synchronised internally, so BOOT occupies the first full clock after release.
- All control outputs are combinational from the current state and inputs. `pc`, the state and the counters are registered.
- Penalties: load-use = 1 bubble; jump = 1 bubble; branch = 2 bubbles (BR_STAGE = 2) or 3 bubbles (BR_STAGE = 3).
- Load-use and `!imem_ready` together count as one stall cycle.
- Reset asserted mid-DRAIN or in HALTED forces BOOT immediately; no partial drain state survives.

## Structure
- Shared package `mips_pkg`:
  - State enum `ctrl_state_t`.
  - `BR_EX` = 2, `BR_MEM` = 3.
- One sub-module, `hazard_detect`: purely combinational load-use compare. Everything else lives in the top.

## Test plan
- Reset release with `imem_ready` = 1 and no hazards: BOOT for 1 cycle, then `pc` = 0, 1, 2, …; with PC_W = 5, `pc` wraps from 31 to 0.
- Load-use, `idex_wr_addr` = 8 = `id_rt_addr`, `id_uses_rt` = 1: `pc` held one cycle, `if_id_en` = 0, `id_ex_flush` = 1, `stall_cnt` = 1. Same setup with `idex_wr_addr` = 0: no stall.
- `br_taken` with `br_target` = 12, asserted together with `id_jump` (`id_jump_addr` = 20), BR_STAGE = 3: next `pc` = 12; three flushes asserted; `flush_cnt` = 1.
- `imem_ready` low for 3 cycles: `pc` constant, `if_id_flush` = 1 each cycle, `stall_cnt` = 3.
- `halt_req` at `pc` = 7:
  - DRAIN for 4 cycles, then `halted` = 1 with all enables 0.
  - Release `halt_req`: RUN next cycle, fetching `pc` = 7.
- With CNT_W = 4, 20 stall cycles: `stall_cnt` stays at 15. Reset asserted mid-DRAIN: immediately `pc` = RESET_PC, outputs at their reset values.
